// File: rtl/uart_word_bridge.sv
// ASCII-hex word bridge between the UART core and the processor shell: RX hex parser feeding a word FIFO, TX word-to-hex serialiser.
// Optional build macro UART_WORD_BRIDGE_ECHO_EN echoes received bytes back through the TX path while it is idle.
//
// TX FSM states:
//   state   | meaning
//   IDLE    | ready for a new word (or an echo byte)
//   SEND    | waiting for UART not busy, then strobe the current byte
//   WAIT_HI | waiting for UART to acknowledge with busy=1
//   WAIT_LO | waiting for UART to finish, then advance to next byte
module uart_word_bridge #(
  parameter int         WORD_W   = 32,
  parameter int         DEPTH    = 4,
  parameter logic [7:0] EOL_CHAR = 8'h0A
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic [7:0]                 i_rx_data,
  input  logic                       i_rx_valid,
  input  logic                       i_tx_busy,
  output logic [7:0]                 o_tx_data,
  output logic                       o_tx_send,
  output logic [WORD_W-1:0]          o_word,
  output logic                       o_word_valid,
  input  logic                       i_word_pop,
  output logic [$clog2(DEPTH):0]     o_fill,
  output logic                       o_overflow,
  input  logic [WORD_W-1:0]          i_tx_word,
  input  logic                       i_tx_start,
  output logic                       o_tx_ready
);

  localparam int NDIG = (WORD_W + 3) / 4;
  localparam int TW   = 4 * NDIG;
  localparam int AW   = $clog2(DEPTH);
  localparam int FW   = AW + 1;
  localparam int IW   = $clog2(NDIG + 2);

  // ---------------- RX parser ----------------
  logic [3:0]        nib;
  logic              is_hex;
  logic [WORD_W-1:0] acc_q, acc_shift;
  logic              dig_q;
  logic              push_req;

  always_comb begin
    nib    = 4'h0;
    is_hex = 1'b0;
    if (i_rx_data >= 8'h30 && i_rx_data <= 8'h39) begin
      is_hex = 1'b1;
      nib    = i_rx_data[3:0];
    end else if ((i_rx_data >= 8'h41 && i_rx_data <= 8'h46) ||
                 (i_rx_data >= 8'h61 && i_rx_data <= 8'h66)) begin
      is_hex = 1'b1;
      nib    = i_rx_data[3:0] + 4'd9;
    end
  end

  if (WORD_W > 4) begin : g_wide
    assign acc_shift = {acc_q[WORD_W-5:0], nib};
  end else begin : g_narrow
    assign acc_shift = nib;
  end

  assign push_req = i_rx_valid && !is_hex && (i_rx_data == EOL_CHAR) && dig_q;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      acc_q <= '0;
      dig_q <= 1'b0;
    end else if (i_rx_valid) begin
      if (is_hex) begin
        acc_q <= acc_shift;
        dig_q <= 1'b1;
      end else if (i_rx_data == EOL_CHAR) begin
        acc_q <= '0;
        dig_q <= 1'b0;
      end
    end
  end

  // ---------------- word FIFO ----------------
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_q, rd_q;
  logic [FW-1:0]     count_q;
  logic              full, empty, do_push, do_pop, ovf_q;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FW'(DEPTH));
  assign do_pop  = i_word_pop && !empty;
  assign do_push = push_req && (!full || do_pop);

  always_ff @(posedge i_Clk) begin
    if (do_push) mem[wr_q] <= acc_q;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + FW'(1);
      else if (do_pop && !do_push) count_q <= count_q - FW'(1);
      if (push_req && !do_push)    ovf_q   <= 1'b1;
    end
  end

  // Stale entries stay hidden so the head reads zero whenever the FIFO is empty.
  assign o_word       = empty ? '0 : mem[rd_q];
  assign o_word_valid = !empty;
  assign o_fill       = count_q;
  assign o_overflow   = ovf_q;

  // ---------------- TX FSM ----------------
  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_HI, ST_WAIT_LO} tx_state_t;

  tx_state_t     state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] word_q, word_d;
  logic [7:0]    data_q, data_d, byte_cur;
  logic          send_q, send_d;
  logic          last_byte;
`ifdef UART_WORD_BRIDGE_ECHO_EN
  logic [7:0]    echo_q, echo_d;
  logic          echo_mode_q, echo_mode_d;
`endif

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    if (idx_q < IW'(NDIG))       byte_cur = hex_char(word_q[TW-1 -: 4]);
    else if (idx_q == IW'(NDIG)) byte_cur = 8'h0D;
    else                         byte_cur = 8'h0A;
    last_byte = (idx_q == IW'(NDIG + 1));
`ifdef UART_WORD_BRIDGE_ECHO_EN
    if (echo_mode_q) begin
      byte_cur  = echo_q;
      last_byte = 1'b1;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    data_d  = data_q;
    send_d  = 1'b0;
`ifdef UART_WORD_BRIDGE_ECHO_EN
    echo_d      = echo_q;
    echo_mode_d = echo_mode_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_tx_start) begin
          word_d  = TW'(i_tx_word);
          idx_d   = '0;
          state_d = ST_SEND;
        end
`ifdef UART_WORD_BRIDGE_ECHO_EN
        // A received byte wins over a same-cycle start request.
        echo_mode_d = 1'b0;
        if (i_rx_valid) begin
          echo_d      = i_rx_data;
          echo_mode_d = 1'b1;
          word_d      = word_q;
          idx_d       = '0;
          state_d     = ST_SEND;
        end
`endif
      end
      ST_SEND: begin
        if (!i_tx_busy) begin
          send_d  = 1'b1;
          data_d  = byte_cur;
          state_d = ST_WAIT_HI;
          if (idx_q < IW'(NDIG)) word_d = word_q << 4;
        end
      end
      ST_WAIT_HI: begin
        if (i_tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!i_tx_busy) begin
          if (last_byte) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      data_q  <= '0;
      send_q  <= 1'b0;
`ifdef UART_WORD_BRIDGE_ECHO_EN
      echo_q      <= '0;
      echo_mode_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      data_q  <= data_d;
      send_q  <= send_d;
`ifdef UART_WORD_BRIDGE_ECHO_EN
      echo_q      <= echo_d;
      echo_mode_q <= echo_mode_d;
`endif
    end
  end

  assign o_tx_data  = data_q;
  assign o_tx_send  = send_q;
  assign o_tx_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_word_bridge.sv
// Self-checking bench for uart_word_bridge: vector table, queue-based RX model, TX byte scoreboard, reset and echo corners.
`timescale 1ns/1ps
module tb_uart_word_bridge;
  localparam int WORD_W = 32;
  localparam int DEPTH  = 4;
  localparam int FW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic [WORD_W-1:0] word;
  logic              word_valid;
  logic              word_pop = 1'b0;
  logic [FW-1:0]     fill;
  logic              overflow;
  logic [WORD_W-1:0] tx_word = '0;
  logic              tx_start = 1'b0;
  logic              tx_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_word_bridge #(.WORD_W(WORD_W), .DEPTH(DEPTH), .EOL_CHAR(8'h0A)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid), .i_tx_busy(tx_busy),
    .o_tx_data(tx_data), .o_tx_send(tx_send),
    .o_word(word), .o_word_valid(word_valid), .i_word_pop(word_pop),
    .o_fill(fill), .o_overflow(overflow),
    .i_tx_word(tx_word), .i_tx_start(tx_start), .o_tx_ready(tx_ready)
  );

  // UART transmitter stand-in: busy rises one cycle after a send and stays up busy_len cycles
  int busy_len = 20;
  int busy_cnt;
  always @(posedge clk or negedge rst_n)
    if (!rst_n)              busy_cnt <= 0;
    else if (tx_send)        busy_cnt <= busy_len + 1;
    else if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
  assign tx_busy = (busy_cnt != 0) && (busy_cnt <= busy_len);

  logic [7:0] txq[$];
  int strobes = 0;
  always @(negedge clk) if (tx_send) begin txq.push_back(tx_data); strobes++; end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // ---- RX reference model: words as plain numbers in a queue ----
  logic [WORD_W-1:0] m_q[$];
  logic [WORD_W-1:0] m_acc;
  bit m_dig;
  bit m_ovf;

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete(); m_acc = '0; m_dig = 0; m_ovf = 0;
  endtask

  task automatic model_cycle(input bit v, input logic [7:0] b, input bit pop);
    int h;
    if (pop && m_q.size() > 0) void'(m_q.pop_front());
    if (v) begin
      h = hexval(b);
      if (h >= 0) begin
        m_acc = m_acc * 16 + WORD_W'(h);
        m_dig = 1;
      end else if (b == 8'h0A) begin
        if (m_dig) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_acc);
          else m_ovf = 1;
        end
        m_acc = '0; m_dig = 0;
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] b, input bit pop);
    rx_valid = v; rx_data = b; word_pop = pop;
    model_cycle(v, b, pop);
    @(posedge clk); #1;
    rx_valid = 0; word_pop = 0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) cycle(1, s[i], 0);
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".fill"}, fill, m_q.size());
    chk({tag, ".valid"}, word_valid, m_q.size() != 0);
    if (m_q.size() != 0) chk({tag, ".word"}, word, m_q[0]);
    chk({tag, ".ovf"}, overflow, m_ovf);
  endtask

  task automatic do_reset();
    rst_n = 0; rx_valid = 0; word_pop = 0; tx_start = 0; model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!tx_ready && n < 3000) begin @(posedge clk); #1; n++; end
    chk({tag, ".ready"}, tx_ready, 1);
  endtask

  task automatic tx_check(input logic [31:0] w, input int blen, input bit poke, input string tag);
    logic [7:0] exp[$];
    logic [3:0] nv;
    busy_len = blen;
    wait_ready({tag, ".pre"});
    txq.delete();
    tx_word = w; tx_start = 1;
    @(posedge clk); #1 tx_start = 0;
    chk({tag, ".busy_ready"}, tx_ready, 0);
    if (poke) begin
      repeat (5) @(posedge clk);
      #1 tx_word = 32'h12345678; tx_start = 1;
      @(posedge clk); #1 tx_start = 0;
    end
    wait_ready({tag, ".done"});
    repeat (30) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      nv = 4'((w / (32'd1 << (28 - 4 * i))) % 16);
      exp.push_back(nv < 10 ? 8'd48 + 8'(nv) : 8'd55 + 8'(nv));
    end
    exp.push_back(8'h0D); exp.push_back(8'h0A);
    chk({tag, ".count"}, txq.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("%s.byte%0d", tag, i), (i < txq.size()) ? txq[i] : 8'h00, exp[i]);
  endtask

  typedef struct {
    string       rx;
    int          pops;
    logic [31:0] exp_word;
    int          exp_fill;
  } vec_t;
  vec_t vecs[10];

  initial begin
    int base, n;
    string cs;
    vecs[0] = '{"1A2b\n",          0, 32'h00001A2B, 1};
    vecs[1] = '{"",                1, 32'h00000000, 0};
    vecs[2] = '{"123456789\r\n",   0, 32'h23456789, 1};
    vecs[3] = '{"\r\n",            0, 32'h23456789, 1};
    vecs[4] = '{" ffFF zz\n",      0, 32'h23456789, 2};
    vecs[5] = '{"",                1, 32'h0000FFFF, 1};
    vecs[6] = '{"g0\r\n",          0, 32'h0000FFFF, 2};
    vecs[7] = '{"",                1, 32'h00000000, 1};
    vecs[8] = '{"",                1, 32'h00000000, 0};
    vecs[9] = '{"\n",              0, 32'h00000000, 0};

    #2 rst_n = 0;
    #2;
    chk("rst.tx_send", tx_send, 0);
    chk("rst.tx_data", tx_data, 0);
    chk("rst.word", word, 0);
    chk("rst.valid", word_valid, 0);
    chk("rst.fill", fill, 0);
    chk("rst.ovf", overflow, 0);
    chk("rst.ready", tx_ready, 1);
    do_reset();

    foreach (vecs[k]) begin
      send_str(vecs[k].rx);
      for (int p = 0; p < vecs[k].pops; p++) cycle(0, 8'h00, 1);
      chk($sformatf("vec%0d.fill", k), fill, vecs[k].exp_fill);
      chk($sformatf("vec%0d.valid", k), word_valid, vecs[k].exp_fill != 0);
      if (vecs[k].exp_fill != 0) chk($sformatf("vec%0d.word", k), word, vecs[k].exp_word);
    end

    // overflow on a full FIFO, then in-order drain
    do_reset();
    for (int k = 1; k <= 5; k++) send_str($sformatf("%0d\n", k));
    chk("ovf.fill", fill, 4);
    chk("ovf.flag", overflow, 1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf.pop%0d", k), word, k);
      cycle(0, 8'h00, 1);
    end
    chk("ovf.empty", word_valid, 0);
    chk("ovf.sticky", overflow, 1);

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int k = 6; k <= 9; k++) send_str($sformatf("%0d\n", k));
    cycle(1, "A", 0);
    cycle(1, 8'h0A, 1);
    chk("fullpp.fill", fill, 4);
    chk("fullpp.ovf", overflow, 0);
    for (int k = 7; k <= 10; k++) begin
      chk($sformatf("fullpp.pop%0d", k), word, k);
      cycle(0, 8'h00, 1);
    end
    // empty FIFO with simultaneous push and pop
    cycle(1, "B", 0);
    cycle(1, 8'h0A, 1);
    chk("emptypp.fill", fill, 1);
    chk("emptypp.word", word, 32'h0000000B);
    cycle(0, 8'h00, 1);

    // randomized RX traffic against the model
    do_reset();
    cs = "0123456789abcdefABCDEF\n\n\n\r x";
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, cs[$urandom_range(0, cs.len() - 1)], $urandom_range(0, 15) == 0);
      check_model($sformatf("rnd%0d", i));
    end

    // TX serialisation
    do_reset();
    tx_check(32'hDEADBEEF, 20, 1, "tx_dead");
    for (int i = 0; i < 4; i++)
      tx_check($urandom, $urandom_range(1, 6), $urandom_range(0, 1) == 1, $sformatf("tx_rnd%0d", i));

    // reset mid-parse and mid-transmission
    do_reset();
    busy_len = 4;
    cycle(1, "A", 0);
    cycle(1, "B", 0);
    wait_ready("mid.pre");
    base = strobes;
    tx_word = 32'hDEADBEEF; tx_start = 1;
    @(posedge clk); #1 tx_start = 0;
    n = 0;
    while (strobes - base < 3 && n < 1000) begin @(negedge clk); n++; end
    chk("mid.strobes", strobes - base, 3);
    #2 rst_n = 0; model_reset();
    #1;
    chk("mid.tx_send", tx_send, 0);
    chk("mid.tx_data", tx_data, 0);
    chk("mid.word", word, 0);
    chk("mid.valid", word_valid, 0);
    chk("mid.fill", fill, 0);
    chk("mid.ovf", overflow, 0);
    chk("mid.ready", tx_ready, 1);
    @(posedge clk); #1 rst_n = 1;
    base = strobes;
    repeat (300) @(posedge clk);
    #1;
    chk("mid.no_more", strobes - base, 0);
    send_str("C\n");
    chk("mid.word_c", word, 32'h0000000C);
    chk("mid.fill_c", fill, 1);

    // echo path
    do_reset();
    busy_len = 3;
    base = strobes;
    cycle(1, "x", 0);
    repeat (60) @(posedge clk);
    #1;
`ifdef UART_WORD_BRIDGE_ECHO_EN
    chk("echo.count", strobes - base, 1);
    chk("echo.byte", (txq.size() > 0) ? txq[txq.size() - 1] : 8'h00, 8'h78);
`else
    chk("echo.count", strobes - base, 0);
`endif
    chk("echo.fill", fill, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_word_bridge.md
Name: uart_word_bridge

Overview:
- Parametrised successor to the single-number serial string converter that sits between the UART core and the processor shell.
- RX side: parses ASCII hex digits from the UART receive stream into WORD_W-bit words and buffers them in a DEPTH-entry FIFO for the processor.
- TX side: serialises a WORD_W-bit word from the processor into uppercase ASCII hex followed by CR LF, using the UART's send/busy handshake.

Parameters:
- WORD_W, 32, word width in bits (≥4); NDIG = ceil(WORD_W/4) hex digits.
- DEPTH, 4, RX word FIFO depth; power of two, ≥2.
- EOL_CHAR, 8'h0A, byte that terminates an RX word.

Ports:
- i_Clk  in  1  system clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_rx_data  in  8  byte from UART receiver.
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid.
- i_tx_busy  in  1  UART transmitter busy.
- o_tx_data  out  8  byte to UART transmitter.
- o_tx_send  out  1  one-cycle send strobe to UART.
- o_word  out  WORD_W  FIFO head word.
- o_word_valid  out  1  FIFO not empty.
- i_word_pop  in  1  consume FIFO head; ignored when empty.
- o_fill  out  $clog2(DEPTH)+1  FIFO occupancy.
- o_overflow  out  1  sticky; word dropped on full FIFO.
- i_tx_word  in  WORD_W  word to transmit.
- i_tx_start  in  1  start transmission; accepted only when o_tx_ready=1.
- o_tx_ready  out  1  TX FSM idle and able to accept a word.

Behaviour:
- Reset (async, immediate):
  - all outputs 0 except o_tx_ready=1;
  - FIFO empty, accumulator and digit count cleared, TX FSM to IDLE;
  - applies identically mid-parse or mid-transmission; no further o_tx_send after assertion.
- RX parser (acts on i_rx_valid cycles only):
  - '0'-'9', 'a'-'f', 'A'-'F': acc <= {acc[WORD_W-5:0], nibble}; older digits truncate silently; digit count saturates at 1.
  - EOL_CHAR with digit count 1: push acc into the FIFO, then clear acc and count.
  - EOL_CHAR with digit count 0: no push.
  - Any other byte (CR, space, etc.): ignored.
  - Pushed word becomes visible on o_word / o_word_valid the cycle after the EOL strobe.
- FIFO: circular, pointers wrap modulo DEPTH, first-word-fall-through on o_word.
  - Pop when empty: no effect.
  - Push when full with no pop: word dropped, o_overflow set, held until reset.
  - Push and pop in the same cycle when full: both succeed, o_fill unchanged, no overflow.
  - Push and pop in the same cycle when empty: the push succeeds and the pop is ignored.
- TX FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
  - IDLE: o_tx_ready=1. On i_tx_start, latch i_tx_word (zero-extended to 4*NDIG bits), set index=0, go to SEND.
  - SEND: when i_tx_busy=0, drive o_tx_data and pulse o_tx_send for one cycle, then go to WAIT_HI.
    - Byte sequence: index 0..NDIG-1 gives the hex digit MSB-first ('0'-'9', 'A'-'F'); index NDIG gives 8'h0D; index NDIG+1 gives 8'h0A.
  - WAIT_HI: wait for i_tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for i_tx_busy=0, then index+1. After index NDIG+1, go to IDLE; otherwise go to SEND.
  - o_tx_data holds its value between strobes.
  - i_tx_start while not ready: ignored, no queuing.
- RX and TX are fully independent; simultaneous activity is legal.

Optional Feature:
- Macro: UART_WORD_BRIDGE_ECHO_EN.
- Defined:
  - Each i_rx_valid byte arriving while the TX FSM is in IDLE is loaded into a 1-byte echo register.
  - The FSM sends that single byte via SEND/WAIT_HI/WAIT_LO and then returns to IDLE.
  - o_tx_ready=0 while an echo is pending or in flight; a same-cycle i_tx_start loses to the echo and is ignored.
  - RX bytes arriving while TX is active are not echoed.
- Undefined: no echo register and no echo path; TX is driven only by i_tx_start.

Test Plan:
- WORD_W=32: RX "1A2b\n" → o_word=32'h00001A2B, o_word_valid=1, o_fill=1; i_word_pop → o_word_valid=0, o_fill=0.
- RX "123456789\r\n" → o_word=32'h23456789; RX "\r\n" alone → o_fill unchanged.
- TX i_tx_start with 32'hDEADBEEF, busy model going high 1 cycle after send for 20 cycles → exactly 10 strobes "DEADBEEF\r\n", then o_tx_ready=1; a start mid-send is ignored.
- DEPTH=4: 5 words "1\n".."5\n" without pops → o_fill=4, o_overflow=1; pops return 1,2,3,4. Full FIFO with simultaneous push and pop → no overflow, order preserved.
- Reset pulse after the 3rd TX strobe and mid-parse ("AB" received) → all outputs at reset values immediately, no further strobes; next "C\n" yields 32'h0000000C.
- With UART_WORD_BRIDGE_ECHO_EN, TX idle: RX 'x' → one strobe with o_tx_data=8'h78 and o_fill unchanged; without the macro → zero strobes.
